register_bank: RTL and testbench

Parametrised register bank, NUM_REGS entries of WIDTH bits. Supports addressed load, addressed swap of any two entries, whole-bank rotate, and synchronous clear, with one operation executed per cycle under fixed priority. Provides two combinational read ports, a per-entry written flag, a saturating operation counter and an error pulse. Sits between the operand input path and the ALU operand selection, replacing the fixed two-register A/B store.

---
 rtl/register_bank.sv | 133 +++++++++++++
 tb/tb_register_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Multi-entry operand store: addressed load, swap, whole-bank rotate and clear,
// one operation per cycle, with two combinational read ports.
module register_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    parameter int AW       = 2,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                load,
    input  logic [AW-1:0]       load_addr,
    input  logic                swap,
    input  logic [AW-1:0]       swap_addr_a,
    input  logic [AW-1:0]       swap_addr_b,
    input  logic                rotate,
    input  logic [AW-1:0]       rd_addr_a,
    input  logic [AW-1:0]       rd_addr_b,
    output logic [WIDTH-1:0]    rd_data_a,
    output logic [WIDTH-1:0]    rd_data_b,
    output logic [NUM_REGS-1:0] written,
    output logic [CNT_W-1:0]    op_count,
    output logic                err
);

    localparam logic [AW:0]      NUM_REGS_L = (AW+1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < NUM_REGS_L;
    endfunction

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] written_q, written_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [WIDTH-1:0]    swap_val_a, swap_val_b;
    logic                swap_wr_a, swap_wr_b;
    logic                op_valid;

    // Out-of-range addresses simply match no entry, so they read as zero.
    always_comb begin
        rd_data_a  = '0;
        rd_data_b  = '0;
        swap_val_a = '0;
        swap_val_b = '0;
        swap_wr_a  = 1'b0;
        swap_wr_b  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == AW'(i)) rd_data_a = regs_q[i];
            if (rd_addr_b == AW'(i)) rd_data_b = regs_q[i];
            if (swap_addr_a == AW'(i)) begin
                swap_val_a = regs_q[i];
                swap_wr_a  = written_q[i];
            end
            if (swap_addr_b == AW'(i)) begin
                swap_val_b = regs_q[i];
                swap_wr_b  = written_q[i];
            end
        end
    end

    always_comb begin
        regs_d    = regs_q;
        written_d = written_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        op_valid  = 1'b0;
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
            written_d = '0;
            cnt_d     = '0;
        end else if (load) begin
            if (in_range(load_addr)) begin
                op_valid = 1'b1;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (load_addr == AW'(i)) begin
                        regs_d[i]    = data_in;
                        written_d[i] = 1'b1;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (swap) begin
            if (in_range(swap_addr_a) && in_range(swap_addr_b)) begin
                op_valid = 1'b1;
                // With a == b the second write restores the original value.
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (swap_addr_a == AW'(i)) begin
                        regs_d[i]    = swap_val_b;
                        written_d[i] = swap_wr_b;
                    end
                    if (swap_addr_b == AW'(i)) begin
                        regs_d[i]    = swap_val_a;
                        written_d[i] = swap_wr_a;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (rotate) begin
            op_valid  = 1'b1;
            regs_d[0] = regs_q[NUM_REGS-1];
            for (int i = 1; i < NUM_REGS; i++) regs_d[i] = regs_q[i-1];
            written_d = {written_q[NUM_REGS-2:0], written_q[NUM_REGS-1]};
        end
        if (op_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q    <= '{default: '0};
            written_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            written_q <= written_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign written  = written_q;
    assign op_count = cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_register_bank.sv
// Drives a 4-entry/8-bit-counter bank and a 3-entry/2-bit-counter bank from the
// same inputs and checks both against an array-based reference model.
module tb_register_bank;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0, load = 1'b0, swap = 1'b0, rotate = 1'b0;
    logic [7:0] data_in = '0;
    logic [1:0] load_addr = '0, sa = '0, sb = '0, ra = '0, rb = '0;

    logic [7:0] rda_a, rdb_a, rda_b, rdb_b;
    logic [3:0] wr_a;
    logic [2:0] wr_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       err_a, err_b;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    register_bank u_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .data_in(data_in),
        .load(load), .load_addr(load_addr), .swap(swap),
        .swap_addr_a(sa), .swap_addr_b(sb), .rotate(rotate),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda_a), .rd_data_b(rdb_a),
        .written(wr_a), .op_count(cnt_a), .err(err_a)
    );

    register_bank #(.WIDTH(8), .NUM_REGS(3), .AW(2), .CNT_W(2)) u_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .data_in(data_in),
        .load(load), .load_addr(load_addr), .swap(swap),
        .swap_addr_a(sa), .swap_addr_b(sb), .rotate(rotate),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda_b), .rd_data_b(rdb_b),
        .written(wr_b), .op_count(cnt_b), .err(err_b)
    );

    // Reference model: index 0 mirrors u_a, index 1 mirrors u_b.
    logic [7:0] m_reg [2][4];
    logic       m_wr  [2][4];
    int         m_cnt [2];
    logic       m_err [2];
    int         m_n   [2] = '{4, 3};
    int         m_max [2] = '{255, 3};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_reg[k][i] = '0;
                m_wr[k][i]  = 1'b0;
            end
            m_cnt[k] = 0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [7:0] old_r [4];
        logic       old_w [4];
        int n, a, b;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            n = m_n[k];
            for (int i = 0; i < 4; i++) begin
                old_r[i] = m_reg[k][i];
                old_w[i] = m_wr[k][i];
            end
            m_err[k] = 1'b0;
            ok = 1'b0;
            a = int'(sa);
            b = int'(sb);
            if (clear) begin
                for (int i = 0; i < 4; i++) begin
                    m_reg[k][i] = '0;
                    m_wr[k][i]  = 1'b0;
                end
                m_cnt[k] = 0;
            end else if (load) begin
                if (int'(load_addr) >= n) m_err[k] = 1'b1;
                else begin
                    m_reg[k][load_addr] = data_in;
                    m_wr[k][load_addr]  = 1'b1;
                    ok = 1'b1;
                end
            end else if (swap) begin
                if (a >= n || b >= n) m_err[k] = 1'b1;
                else begin
                    m_reg[k][a] = old_r[b];
                    m_reg[k][b] = old_r[a];
                    m_wr[k][a]  = old_w[b];
                    m_wr[k][b]  = old_w[a];
                    ok = 1'b1;
                end
            end else if (rotate) begin
                for (int i = 0; i < n; i++) begin
                    m_reg[k][i] = old_r[(i + n - 1) % n];
                    m_wr[k][i]  = old_w[(i + n - 1) % n];
                end
                ok = 1'b1;
            end
            if (ok && m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    // One clock edge: model follows the inputs seen at the edge, then ops drop.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        clear = 1'b0; load = 1'b0; swap = 1'b0; rotate = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (wr_a !== 4'h0) begin errors++; $display("FAIL reset_written: got %b expected 0000", wr_a); end
        checks++; if (cnt_a !== 8'h00) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt_a); end
        checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b expected 0/0", err_a, err_b); end
        checks++; if (rda_a !== 8'h00) begin errors++; $display("FAIL reset_read: got %h expected 00", rda_a); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_load_swap();
        ra = 2'd0;
        for (int i = 0; i < 4; i++) begin
            load = 1'b1; load_addr = 2'(i); data_in = 8'(8'h11 * (i + 1));
            if (i == 0) begin
                #1;
                checks++; if (rda_a !== 8'h00) begin errors++; $display("FAIL no_bypass: got %h expected 00", rda_a); end
            end
            tick();
            checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL load_err_a[%0d]: got %b expected 0", i, err_a); end
            checks++; if (err_b !== (i == 3)) begin errors++; $display("FAIL load_err_b[%0d]: got %b expected %b", i, err_b, (i == 3)); end
        end
        for (int i = 0; i < 4; i++) begin
            ra = 2'(i); #1;
            checks++; if (rda_a !== 8'(8'h11 * (i + 1))) begin errors++; $display("FAIL load_read[%0d]: got %h expected %h", i, rda_a, 8'(8'h11 * (i + 1))); end
        end
        checks++; if (rda_b !== 8'h00) begin errors++; $display("FAIL oob_read: got %h expected 00", rda_b); end
        checks++; if (wr_a !== 4'b1111 || wr_b !== 3'b111) begin errors++; $display("FAIL load_written: got %b/%b expected 1111/111", wr_a, wr_b); end
        checks++; if (cnt_a !== 8'd4 || cnt_b !== 2'd3) begin errors++; $display("FAIL load_count: got %0d/%0d expected 4/3", cnt_a, cnt_b); end
        tick();
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", err_b); end

        swap = 1'b1; sa = 2'd0; sb = 2'd3; tick();
        ra = 2'd0; rb = 2'd3; #1;
        checks++; if (rda_a !== 8'h44 || rdb_a !== 8'h11) begin errors++; $display("FAIL swap03: got %h/%h expected 44/11", rda_a, rdb_a); end
        checks++; if (err_b !== 1'b1 || cnt_b !== 2'd3) begin errors++; $display("FAIL swap_oob: got err=%b cnt=%0d expected 1/3", err_b, cnt_b); end
        swap = 1'b1; sa = 2'd1; sb = 2'd1; tick();
        ra = 2'd1; #1;
        checks++; if (rda_a !== 8'h22 || cnt_a !== 8'd6) begin errors++; $display("FAIL swap_same: got %h cnt=%0d expected 22 cnt=6", rda_a, cnt_a); end
    endtask

    task automatic test_rotate();
        clear = 1'b1; tick();
        ra = 2'd0; #1;
        checks++; if (wr_a !== 4'h0 || cnt_a !== 8'd0 || rda_a !== 8'h00) begin errors++; $display("FAIL clear: got wr=%b cnt=%0d rd=%h expected 0", wr_a, cnt_a, rda_a); end
        load = 1'b1; load_addr = 2'd1; data_in = 8'hA5; tick();
        rotate = 1'b1; tick();
        ra = 2'd2; #1;
        checks++; if (rda_a !== 8'hA5 || wr_a !== 4'b0100) begin errors++; $display("FAIL rotate1: got %h wr=%b expected a5 wr=0100", rda_a, wr_a); end
        for (int i = 0; i < 3; i++) begin rotate = 1'b1; tick(); end
        ra = 2'd1; rb = 2'd2; #1;
        checks++; if (rda_a !== 8'hA5 || wr_a !== 4'b0010 || cnt_a !== 8'd5) begin errors++; $display("FAIL rotate4: got %h wr=%b cnt=%0d expected a5 wr=0010 cnt=5", rda_a, wr_a, cnt_a); end
        checks++; if (rdb_b !== 8'hA5 || wr_b !== 3'b100 || cnt_b !== 2'd3) begin errors++; $display("FAIL rotate_n3_sat: got %h wr=%b cnt=%0d expected a5 wr=100 cnt=3", rdb_b, wr_b, cnt_b); end
    endtask

    task automatic test_priority();
        load = 1'b1; load_addr = 2'd0; data_in = 8'h5A;
        swap = 1'b1; sa = 2'd1; sb = 2'd2; rotate = 1'b1; tick();
        ra = 2'd0; rb = 2'd1; #1;
        checks++; if (rda_a !== 8'h5A || rdb_a !== 8'hA5 || wr_a !== 4'b0011 || cnt_a !== 8'd6) begin errors++; $display("FAIL prio_load: got %h/%h wr=%b cnt=%0d expected 5a/a5 wr=0011 cnt=6", rda_a, rdb_a, wr_a, cnt_a); end
        checks++; if (wr_b !== 3'b101) begin errors++; $display("FAIL prio_load_b: got %b expected 101", wr_b); end
        clear = 1'b1; load = 1'b1; swap = 1'b1; rotate = 1'b1; tick();
        checks++; if (rda_a !== 8'h00 || rdb_a !== 8'h00 || wr_a !== 4'h0 || cnt_a !== 8'd0 || wr_b !== 3'h0 || cnt_b !== 2'd0) begin errors++; $display("FAIL prio_clear: got %h/%h wr=%b cnt=%0d expected all 0", rda_a, rdb_a, wr_a, cnt_a); end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_addr = 2'd3; data_in = 8'h77; tick();
        ra = 2'd3; #1;
        checks++; if (rda_a !== 8'h77 || err_b !== 1'b1) begin errors++; $display("FAIL pre_reset: got %h err=%b expected 77 err=1", rda_a, err_b); end
        #3; reset_n = 1'b0; #1;
        checks++; if (rda_a !== 8'h00 || wr_a !== 4'h0 || cnt_a !== 8'd0 || err_b !== 1'b0) begin errors++; $display("FAIL async_reset: got %h wr=%b cnt=%0d err=%b expected 0", rda_a, wr_a, cnt_a, err_b); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [3:0] ew_a;
        logic [2:0] ew_b;
        logic [7:0] exp_b;
        for (int it = 0; it < 300; it++) begin
            clear     = ($urandom_range(0, 15) == 0);
            load      = ($urandom_range(0, 2) == 0);
            swap      = 1'($urandom);
            rotate    = 1'($urandom);
            load_addr = 2'($urandom_range(0, 3));
            sa        = 2'($urandom_range(0, 3));
            sb        = 2'($urandom_range(0, 3));
            data_in   = 8'($urandom);
            tick();
            for (int i = 0; i < 4; i++) ew_a[i] = m_wr[0][i];
            for (int i = 0; i < 3; i++) ew_b[i] = m_wr[1][i];
            checks++; if (wr_a !== ew_a || wr_b !== ew_b) begin errors++; $display("FAIL rnd_written[%0d]: got %b/%b expected %b/%b", it, wr_a, wr_b, ew_a, ew_b); end
            checks++; if (int'(cnt_a) != m_cnt[0] || int'(cnt_b) != m_cnt[1]) begin errors++; $display("FAIL rnd_count[%0d]: got %0d/%0d expected %0d/%0d", it, cnt_a, cnt_b, m_cnt[0], m_cnt[1]); end
            checks++; if (err_a !== m_err[0] || err_b !== m_err[1]) begin errors++; $display("FAIL rnd_err[%0d]: got %b/%b expected %b/%b", it, err_a, err_b, m_err[0], m_err[1]); end
            for (int i = 0; i < 4; i++) begin
                ra = 2'(i); rb = 2'(3 - i); #1;
                checks++; if (rda_a !== m_reg[0][i] || rdb_a !== m_reg[0][3 - i]) begin errors++; $display("FAIL rnd_read_a[%0d,%0d]: got %h/%h expected %h/%h", it, i, rda_a, rdb_a, m_reg[0][i], m_reg[0][3 - i]); end
                exp_b = (i < 3) ? m_reg[1][i] : 8'h00;
                checks++; if (rda_b !== exp_b) begin errors++; $display("FAIL rnd_read_b[%0d,%0d]: got %h expected %h", it, i, rda_b, exp_b); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_swap();
        test_rotate();
        test_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
